cpu_mc_ctrl: RTL and testbench

Multi-cycle control unit for the 32-bit teaching CPU. Sequences the instruction ROM, ALU, register file and data memory through IF/ID/EX/MEM/WB. Owns the PC that addresses the 64-word instruction ROM and the instruction register (IR). Drives all datapath select and enable lines.

---
 rtl/cpu_mc_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_cpu_mc_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mc_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB control unit for the 32-bit teaching CPU: owns pc and ir, drives datapath selects/strobes.
// Optional CPU_MC_PERF_EN adds saturating cycle (cyc_cnt) and retired-instruction (ret_cnt) counters.
module cpu_mc_ctrl #(
  parameter int unsigned PC_W     = 6,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     inst,
  input  logic            zero,
  input  logic            mem_ack,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     ir,
  output logic [2:0]      alu_op,
  output logic            alu_src_imm,
  output logic            rf_we,
  output logic            rf_wsel,
  output logic            wb_sel,
  output logic            mem_req,
  output logic            mem_we,
  output logic [2:0]      state,
`ifdef CPU_MC_PERF_EN
  output logic [31:0]     cyc_cnt,
  output logic [31:0]     ret_cnt,
`endif
  output logic            trap
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_ILL, C_NOP, C_JMP, C_ALU, C_ADDI, C_LOAD, C_STORE, C_BR
  } cls_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;

  state_t            cur, nxt;
  cls_t              cls;
  logic [2:0]        dec_alu_op;
  logic              br_eq;
  logic [PC_W-1:0]   pc_n;
  logic [31:0]       ir_n;
  logic              trap_n;
  logic [5:0]        op, func;

  assign op    = ir[31:26];
  assign func  = ir[25:20];
  assign state = cur;

  // Instruction class decode from the latched IR; held stable from ID through WB.
  always_comb begin
    cls        = C_ILL;
    dec_alu_op = ALU_ADD;
    br_eq      = 1'b0;
    if (ir == '0) begin
      cls = C_NOP;
    end else begin
      case (op)
        6'b000000: case (func)
          6'b000001: begin cls = C_ALU; dec_alu_op = ALU_ADD; end
          6'b000010: begin cls = C_ALU; dec_alu_op = ALU_SUB; end
          default:   cls = C_ILL;
        endcase
        6'b000001: case (func)
          6'b000001: begin cls = C_ALU; dec_alu_op = ALU_AND; end
          6'b000010: begin cls = C_ALU; dec_alu_op = ALU_OR;  end
          default:   cls = C_ILL;
        endcase
        6'b000010: case (func)
          6'b000011: begin cls = C_ALU; dec_alu_op = ALU_SLL; end
          6'b000100: begin cls = C_ALU; dec_alu_op = ALU_SRL; end
          default:   cls = C_ILL;
        endcase
        6'b000101: cls = C_ADDI;
        6'b001101: cls = C_LOAD;
        6'b001110: cls = C_STORE;
        6'b010000: begin cls = C_BR; br_eq = 1'b0; end
        6'b010001: begin cls = C_BR; br_eq = 1'b1; end
        6'b010010: cls = C_JMP;
        default:   cls = C_ILL;
      endcase
    end
  end

  always_comb begin
    nxt         = cur;
    pc_n        = pc;
    ir_n        = ir;
    trap_n      = trap;
    alu_op      = '0;
    alu_src_imm = 1'b0;
    rf_we       = 1'b0;
    rf_wsel     = 1'b0;
    wb_sel      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    case (cur)
      S_IF: begin
        ir_n = inst;
        pc_n = pc + PC_W'(1);
        nxt  = S_ID;
      end
      S_ID: begin
        case (cls)
          C_NOP: nxt = S_IF;
          C_JMP: begin
            pc_n = ir[PC_W-1:0];
            nxt  = S_IF;
          end
          C_ILL: begin
            trap_n = 1'b1;
            nxt    = S_TRAP;
          end
          default: nxt = S_EX;
        endcase
      end
      S_EX: begin
        case (cls)
          C_ALU: begin
            alu_op = dec_alu_op;
            nxt    = S_WB;
          end
          C_ADDI: begin
            alu_op      = ALU_ADD;
            alu_src_imm = 1'b1;
            nxt         = S_WB;
          end
          C_LOAD, C_STORE: begin
            alu_op      = ALU_ADD;
            alu_src_imm = 1'b1;
            nxt         = S_MEM;
          end
          C_BR: begin
            alu_op = ALU_SUB;
            // bne taken on !zero, beq on zero; pc already points past the branch
            if (br_eq == zero) pc_n = pc + ir[10 +: PC_W];
            nxt = S_IF;
          end
          default: nxt = S_IF;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls == C_STORE);
        if (mem_ack) nxt = (cls == C_STORE) ? S_IF : S_WB;
      end
      S_WB: begin
        rf_we   = 1'b1;
        rf_wsel = (cls != C_ALU);
        wb_sel  = (cls == C_LOAD);
        nxt     = S_IF;
      end
      S_TRAP: nxt = S_TRAP;
      default: nxt = S_IF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur  <= S_IF;
      pc   <= PC_W'(RESET_PC);
      ir   <= '0;
      trap <= 1'b0;
    end else begin
      cur  <= nxt;
      pc   <= pc_n;
      ir   <= ir_n;
      trap <= trap_n;
    end
  end

`ifdef CPU_MC_PERF_EN
  logic retire;

  always_comb begin
    retire = 1'b0;
    case (cur)
      S_ID:    retire = (cls == C_NOP) || (cls == C_JMP);
      S_EX:    retire = (cls == C_BR);
      S_MEM:   retire = mem_ack && (cls == C_STORE);
      S_WB:    retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + 32'd1;
      if (retire && (ret_cnt != '1)) ret_cnt <= ret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_mc_ctrl.sv
// Directed bench for cpu_mc_ctrl: add, delayed-ack load, bne both ways, JMP wrap, trap, async reset mid-store.
module tb_cpu_mc_ctrl;
  logic        clk;
  logic        rst_n;
  logic [31:0] inst;
  logic        zero;
  logic        mem_ack;
  logic [5:0]  pc;
  logic [31:0] ir;
  logic [2:0]  alu_op;
  logic        alu_src_imm;
  logic        rf_we;
  logic        rf_wsel;
  logic        wb_sel;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  state;
  logic        trap;
`ifdef CPU_MC_PERF_EN
  logic [31:0] cyc_cnt;
  logic [31:0] ret_cnt;
`endif

  logic [31:0] rom [64];
  int total = 0;
  int bad   = 0;

  assign inst = rom[pc];

  cpu_mc_ctrl #(.PC_W(6), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .zero(zero), .mem_ack(mem_ack),
    .pc(pc), .ir(ir), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
    .rf_we(rf_we), .rf_wsel(rf_wsel), .wb_sel(wb_sel),
    .mem_req(mem_req), .mem_we(mem_we), .state(state),
`ifdef CPU_MC_PERF_EN
    .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt),
`endif
    .trap(trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = '0;
    rom[0]  = 32'h00100443; // add
    rom[1]  = 32'h34FFD501; // load
    rom[5]  = 32'h40000C00; // bne imm16=3
    rom[6]  = 32'h4800003F; // jmp 0x3F
    rom[9]  = 32'h48000005; // jmp 5
    rom[63] = 32'hFC000000; // illegal
    rst_n = 1'b0; zero = 1'b0; mem_ack = 1'b0;

    #2;
    chk("rst_state", 32'(state), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_ir", ir, 0);
    chk("rst_trap", 32'(trap), 0);
    chk("rst_strobes", {25'b0, rf_we, mem_req, mem_we, alu_src_imm, rf_wsel, wb_sel, 1'b0}, 0);
    tick();
    rst_n = 1'b1;

    // add at pc 0; mem_ack held high outside MEM must have no effect
    chk("add_if", 32'(state), 0);
    mem_ack = 1'b1;
    tick();
    chk("add_id", 32'(state), 1);
    chk("add_id_pc", 32'(pc), 1);
    chk("add_ir", ir, 32'h00100443);
    chk("add_id_rfwe", 32'(rf_we), 0);
    tick();
    chk("add_ex", 32'(state), 2);
    chk("add_ex_aluop", 32'(alu_op), 0);
    chk("add_ex_imm", 32'(alu_src_imm), 0);
    chk("add_ex_rfwe", 32'(rf_we), 0);
    chk("add_ex_memreq", 32'(mem_req), 0);
    tick();
    chk("add_wb", 32'(state), 4);
    chk("add_wb_rfwe", 32'(rf_we), 1);
    chk("add_wb_wsel", 32'(rf_wsel), 0);
    chk("add_wb_wbsel", 32'(wb_sel), 0);
    mem_ack = 1'b0;
    tick();
    chk("add_done_state", 32'(state), 0);
    chk("add_done_rfwe", 32'(rf_we), 0);
    chk("add_done_pc", 32'(pc), 1);

    // load at pc 1, ack in the 4th MEM cycle: 8 cycles total
    tick();
    chk("ld_id", 32'(state), 1);
    tick();
    chk("ld_ex", 32'(state), 2);
    chk("ld_ex_imm", 32'(alu_src_imm), 1);
    chk("ld_ex_aluop", 32'(alu_op), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("ld_mem_state", 32'(state), 3);
      chk("ld_mem_req", 32'(mem_req), 1);
      chk("ld_mem_we", 32'(mem_we), 0);
      if (k == 3) mem_ack = 1'b1;
    end
    tick();
    mem_ack = 1'b0;
    chk("ld_wb", 32'(state), 4);
    chk("ld_wb_memreq", 32'(mem_req), 0);
    chk("ld_wb_rfwe", 32'(rf_we), 1);
    chk("ld_wb_wbsel", 32'(wb_sel), 1);
    chk("ld_wb_wsel", 32'(rf_wsel), 1);
    tick();
    chk("ld_done_state", 32'(state), 0);
    chk("ld_done_pc", 32'(pc), 2);

    // three NOPs at pc 2..4, 2 cycles each
    for (int k = 0; k < 3; k++) begin
      chk("nop_if", 32'(state), 0);
      chk("nop_pc", 32'(pc), 32'(2 + k));
      tick();
      chk("nop_id", 32'(state), 1);
      tick();
    end

    // bne at pc 5, zero=0: taken to 6+3=9
    chk("bne0_pc", 32'(pc), 5);
    tick();
    tick();
    chk("bne0_ex", 32'(state), 2);
    chk("bne0_aluop", 32'(alu_op), 1);
    chk("bne0_imm", 32'(alu_src_imm), 0);
    chk("bne0_rfwe", 32'(rf_we), 0);
    chk("bne0_memreq", 32'(mem_req), 0);
    tick();
    chk("bne0_state", 32'(state), 0);
    chk("bne0_target", 32'(pc), 9);

    // jmp 5 at pc 9
    tick();
    tick();
    chk("jmp5_pc", 32'(pc), 5);
    chk("jmp5_state", 32'(state), 0);

    // bne at pc 5, zero=1: not taken
    tick();
    zero = 1'b1;
    tick();
    chk("bne1_aluop", 32'(alu_op), 1);
    chk("bne1_rfwe", 32'(rf_we), 0);
    chk("bne1_memreq", 32'(mem_req), 0);
    tick();
    zero = 1'b0;
    chk("bne1_pc", 32'(pc), 6);

    // jmp 0x3F, then the fetch there wraps pc to 0 and the illegal word traps
    tick();
    tick();
    chk("jmp3f_pc", 32'(pc), 63);
    tick();
    chk("wrap_pc", 32'(pc), 0);
    chk("wrap_ir", ir, 32'hFC000000);
    tick();
    for (int k = 0; k < 20; k++) begin
      zero = k[0];
      mem_ack = 1'b1;
      chk("trap_state", 32'(state), 7);
      chk("trap_flag", 32'(trap), 1);
      chk("trap_pc", 32'(pc), 0);
      chk("trap_strobes", {29'b0, rf_we, mem_req, mem_we}, 0);
      tick();
    end
    mem_ack = 1'b0;
    zero = 1'b0;

    // reset pulse clears trap; store at pc 0 for the mid-MEM reset case
    rom[0] = 32'h38000C22;
    #2 rst_n = 1'b0;
    #1;
    chk("trapclr_trap", 32'(trap), 0);
    chk("trapclr_pc", 32'(pc), 0);
    chk("trapclr_state", 32'(state), 0);
    tick();
    rst_n = 1'b1;

    tick();
    chk("st_id_ir", ir, 32'h38000C22);
    tick();
    chk("st_ex_imm", 32'(alu_src_imm), 1);
    chk("st_ex_aluop", 32'(alu_op), 0);
    tick();
    chk("st_mem_req", 32'(mem_req), 1);
    chk("st_mem_we", 32'(mem_we), 1);
    tick();
    chk("st_mem_hold", 32'(mem_req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("st_arst_memreq", 32'(mem_req), 0);
    chk("st_arst_memwe", 32'(mem_we), 0);
    chk("st_arst_state", 32'(state), 0);
    chk("st_arst_pc", 32'(pc), 0);
    tick();
    rst_n = 1'b1;

    // refetch from pc 0; store completes with immediate ack and never writes the RF
    chk("st2_if_pc", 32'(pc), 0);
    chk("st2_if_rfwe", 32'(rf_we), 0);
    tick();
    chk("st2_id_rfwe", 32'(rf_we), 0);
    tick();
    chk("st2_ex_rfwe", 32'(rf_we), 0);
    tick();
    chk("st2_mem_state", 32'(state), 3);
    chk("st2_mem_we", 32'(mem_we), 1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("st2_done_state", 32'(state), 0);
    chk("st2_done_pc", 32'(pc), 1);
    chk("st2_done_rfwe", 32'(rf_we), 0);
    chk("st2_done_memreq", 32'(mem_req), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
